// File: rtl/conv3_dw_window_pkg.sv
// Shared definitions for the 3x3 depthwise window generator.
//   state_e      : window FSM states (FILL / STREAM / FLUSH)
//   T_TL..T_BR   : tap indices, row-major, T_MC is the centre pixel
//   cnt_w        : counter width helper (never narrower than 1 bit)
//   tap_sr_index : which history slot feeds a given tap
package conv3_dw_window_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  localparam int NTAPS = 9;

  localparam int T_TL = 0;
  localparam int T_TC = 1;
  localparam int T_TR = 2;
  localparam int T_ML = 3;
  localparam int T_MC = 4;
  localparam int T_MR = 5;
  localparam int T_BL = 6;
  localparam int T_BC = 7;
  localparam int T_BR = 8;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Slot 0 of the history holds the newest pixel. When the centre sits
  // IMG_W+1 slots back, tap (dr,dc) with dr,dc in 0..2 lives at
  // 2*IMG_W+2 - dr*IMG_W - dc.
  function automatic int tap_sr_index(input int img_w, input int t);
    return 2 * img_w + 2 - (t / 3) * img_w - (t % 3);
  endfunction

endpackage

// File: rtl/conv3_dw_pad_mask.sv
// Combinational zero-padding mask.
//   row, col : centre pixel coordinates of the window being formed
//   mask     : bit t set when tap t lies inside the image
// The column test is what stops a left/right tap from picking up a pixel
// of the neighbouring row out of the linear history.
module conv3_dw_pad_mask
  import conv3_dw_window_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic [cnt_w(IMG_H)-1:0] row,
  input  logic [cnt_w(IMG_W)-1:0] col,
  output logic [NTAPS-1:0]        mask
);

  localparam int RW = cnt_w(IMG_H);
  localparam int CW = cnt_w(IMG_W);

  logic [2:0] row_ok;
  logic [2:0] col_ok;

  always_comb begin
    // index 0 = above/left, 1 = centre, 2 = below/right
    row_ok = {(row != RW'(IMG_H - 1)), 1'b1, (row != '0)};
    col_ok = {(col != CW'(IMG_W - 1)), 1'b1, (col != '0)};
    mask   = '0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        mask[dr * 3 + dc] = row_ok[dr] & col_ok[dc];
      end
    end
  end

endmodule

// File: rtl/conv3_dw_window.sv
// 3x3 sliding-window generator with same-size zero padding, stride 1.
//   clk, rst   : single clock, synchronous active-high reset
//   valid      : input_act carries one raster-order pixel this cycle
//   input_act  : pixel, channel n at [n*DW +: DW]
//   output_act : window, tap t at [t*CH*DW +: CH*DW] (row-major, t4 = centre)
//   ready      : one-cycle pulse, output_act holds a new window
//   overrun    : sticky, set when a pixel arrives while the frame drains
// Handshake: there is no back-pressure. A pixel is taken on every rising
// edge where valid is high and the block is not flushing; a window is
// presented for exactly the one cycle ready is high and output_act then
// holds until the next window.
module conv3_dw_window
  import conv3_dw_window_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int CH    = 16,
  parameter int DW    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid,
  input  logic [CH*DW-1:0]        input_act,
  output logic [NTAPS*CH*DW-1:0]  output_act,
  output logic                    ready,
  output logic                    overrun
);

  localparam int PW     = CH * DW;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int SR_LEN = 2 * IMG_W + 3;
  localparam int RW     = cnt_w(IMG_H);
  localparam int CW     = cnt_w(IMG_W);
  localparam int IW     = cnt_w(NPIX);
  localparam int FW     = cnt_w(IMG_W + 1);

  state_e               state;
  state_e               state_next;

  logic                 accept;
  logic                 flush_step;
  logic                 emit;
  logic                 drop;

  logic [IW-1:0]        in_cnt;
  logic [FW-1:0]        flush_cnt;
  logic [RW-1:0]        crow;
  logic [CW-1:0]        ccol;

  logic [NTAPS-1:0]     mask;
  logic [PW-1:0]        sr_q    [SR_LEN];
  logic [PW-1:0]        sr_next [SR_LEN];
  logic [NTAPS*PW-1:0]  window;

  logic [NTAPS*PW-1:0]  out_q;
  logic                 ready_q;
  logic                 overrun_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    unique case (state)
      FILL:   if (valid && in_cnt == IW'(IMG_W))     state_next = STREAM;
      STREAM: if (valid && in_cnt == IW'(NPIX - 1))  state_next = FLUSH;
      FLUSH:  if (flush_cnt == FW'(IMG_W))           state_next = FILL;
      default:                                       state_next = FILL;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    accept     = valid && (state != FLUSH);
    flush_step = (state == FLUSH);
    emit       = (valid && state == STREAM) || flush_step;
    drop       = valid && flush_step;
  end

  // ---------------- history and window ----------------
  // The window is taken from the history as it will look after this
  // cycle's shift, so it appears on the output one cycle after the
  // triggering accept or flush step. Flush steps shift in zeros.
  always_comb begin
    sr_next[0] = accept ? input_act : '0;
    for (int i = 1; i < SR_LEN; i++) sr_next[i] = sr_q[i - 1];
  end

  conv3_dw_pad_mask #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_pad_mask (
    .row  (crow),
    .col  (ccol),
    .mask (mask)
  );

  always_comb begin
    window = '0;
    for (int t = 0; t < NTAPS; t++) begin
      window[t * PW +: PW] = mask[t] ? sr_next[tap_sr_index(IMG_W, t)] : '0;
    end
  end

  // ---------------- counters and datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt    <= '0;
      flush_cnt <= '0;
      crow      <= '0;
      ccol      <= '0;
      out_q     <= '0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < SR_LEN; i++) sr_q[i] <= '0;
    end else begin
      ready_q <= emit;

      if (accept) begin
        in_cnt <= (in_cnt == IW'(NPIX - 1)) ? '0 : in_cnt + IW'(1);
      end

      if (flush_step) begin
        flush_cnt <= (flush_cnt == FW'(IMG_W)) ? '0 : flush_cnt + FW'(1);
      end

      if (accept || flush_step) begin
        for (int i = 0; i < SR_LEN; i++) sr_q[i] <= sr_next[i];
      end

      if (emit) begin
        out_q <= window;
        if (ccol == CW'(IMG_W - 1)) begin
          ccol <= '0;
          crow <= (crow == RW'(IMG_H - 1)) ? '0 : crow + RW'(1);
        end else begin
          ccol <= ccol + CW'(1);
        end
      end

      if (drop) overrun_q <= 1'b1;
    end
  end

  assign output_act = out_q;
  assign ready      = ready_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_conv3_dw_window.sv
// Bench for conv3_dw_window: directed ramp/corner/gap/overrun/reset
// scenarios plus random frames, checked against a coordinate-based
// window model and a cycle-level ready model.
module tb_conv3_dw_window;

  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int CH    = 16;
  localparam int DW    = 16;
  localparam int PW    = CH * DW;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int WW    = 9 * PW;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic [PW-1:0] input_act;
  logic [WW-1:0] output_act;
  logic          ready;
  logic          overrun;

  always #5 clk = ~clk;

  conv3_dw_window #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CH    (CH),
    .DW    (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .input_act  (input_act),
    .output_act (output_act),
    .ready      (ready),
    .overrun    (overrun)
  );

  // ---------------- bookkeeping ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [PW-1:0] frame [NPIX];
  logic [WW-1:0] exp_q [$];
  logic [WW-1:0] got_win [NPIX];

  function automatic logic [PW-1:0] ramp_val(input int v);
    logic [PW-1:0] p;
    for (int c = 0; c < CH; c++) p[c * DW +: DW] = DW'(v);
    return p;
  endfunction

  // Window for centre k straight from image coordinates.
  function automatic logic [WW-1:0] ref_window(input int k);
    logic [WW-1:0] w;
    int r, c, rr, cc;
    w = '0;
    r = k / IMG_W;
    c = k % IMG_W;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
        if (rr >= 0 && rr < IMG_H && cc >= 0 && cc < IMG_W)
          w[((dr + 1) * 3 + (dc + 1)) * PW +: PW] = frame[rr * IMG_W + cc];
      end
    end
    return w;
  endfunction

  task automatic fill_ramp();
    for (int i = 0; i < NPIX; i++) frame[i] = ramp_val(i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NPIX; i++)
      for (int c = 0; c < CH; c++) frame[i][c * DW +: DW] = DW'($urandom);
  endtask

  task automatic load_expected();
    for (int k = 0; k < NPIX; k++) exp_q.push_back(ref_window(k));
  endtask

  // Ready model: windows start with the (IMG_W+2)th pixel of a frame and
  // continue for IMG_W+1 drain cycles after the last pixel.
  int   cyc     = 0;
  int   m_cnt   = 0;
  int   m_flush = 0;
  logic exp_rdy = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_cnt   <= 0;
      m_flush <= 0;
      exp_rdy <= 1'b0;
    end else if (m_flush > 0) begin
      exp_rdy <= 1'b1;
      m_flush <= m_flush - 1;
    end else if (valid) begin
      exp_rdy <= (m_cnt >= IMG_W + 1);
      if (m_cnt == NPIX - 1) begin
        m_cnt   <= 0;
        m_flush <= IMG_W + 1;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else begin
      exp_rdy <= 1'b0;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  int rdy_cnt       = 0;
  int win_idx       = 0;
  int first_rdy_cyc = -1;
  int fv_cyc        = 0;

  always @(negedge clk) begin
    logic [WW-1:0] w;
    chk("ready", PW'(ready), PW'(exp_rdy));
    if (ready) begin
      rdy_cnt++;
      if (first_rdy_cyc < 0) first_rdy_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("win_extra", PW'(1), PW'(0));
      end else begin
        w = exp_q.pop_front();
        if (win_idx < NPIX) got_win[win_idx] = output_act;
        for (int t = 0; t < 9; t++)
          chk($sformatf("win%0d_t%0d", win_idx, t), output_act[t * PW +: PW], w[t * PW +: PW]);
      end
      win_idx++;
    end
  end

  // ---------------- driver tasks ----------------
  // gap_mode 0: back-to-back, 1: one valid in three cycles, 2: random gaps
  task automatic drive_frame(input int gap_mode, input int npix);
    for (int i = 0; i < npix; i++) begin
      int gaps;
      gaps = (gap_mode == 1) ? 2 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
      repeat (gaps) begin
        @(negedge clk);
        valid = 1'b0;
      end
      @(negedge clk);
      valid     = 1'b1;
      input_act = frame[i];
      if (i == 0) fv_cyc = cyc;
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, PW'(exp_q.size()), PW'(0));
    repeat (3) @(negedge clk);
  endtask

  task automatic start_frame(input bit ramp);
    if (ramp) fill_ramp();
    else      fill_random();
    load_expected();
    rdy_cnt       = 0;
    win_idx       = 0;
    first_rdy_cyc = -1;
  endtask

  // ---------------- main sequence ----------------
  int c9_pix [9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
  int z0_tap [5] = '{0, 1, 2, 3, 6};
  int z63_tap[5] = '{2, 5, 6, 7, 8};
  int zw_tap [3] = '{2, 5, 8};

  initial begin
    rst       = 1'b1;
    valid     = 1'b0;
    input_act = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", PW'(ready), PW'(0));
    chk("rst_overrun", PW'(overrun), PW'(0));
    for (int t = 0; t < 9; t++) chk($sformatf("rst_out_t%0d", t), output_act[t * PW +: PW], '0);
    rst = 1'b0;
    @(negedge clk);

    // Ramp frame, valid held high
    start_frame(1'b1);
    drive_frame(0, NPIX);
    drain("ramp_drain");
    chk("ramp_ready_count", PW'(rdy_cnt), PW'(64));
    chk("first_ready_cycle", PW'(first_rdy_cyc - (fv_cyc + 1) + 2), PW'(11));
    for (int t = 0; t < 9; t++)
      chk($sformatf("c9_t%0d", t), got_win[9][t * PW +: PW], ramp_val(c9_pix[t]));
    for (int i = 0; i < 5; i++)
      chk($sformatf("c0_t%0d", z0_tap[i]), got_win[0][z0_tap[i] * PW +: PW], '0);
    for (int i = 0; i < 5; i++)
      chk($sformatf("c63_t%0d", z63_tap[i]), got_win[63][z63_tap[i] * PW +: PW], '0);
    chk("c63_t4", got_win[63][4 * PW +: PW], ramp_val(63));
    for (int i = 0; i < 3; i++)
      chk($sformatf("c15_t%0d", zw_tap[i]), got_win[15][zw_tap[i] * PW +: PW], '0);
    chk("c15_t4", got_win[15][4 * PW +: PW], ramp_val(15));
    chk("c15_t1", got_win[15][1 * PW +: PW], ramp_val(7));
    chk("ramp_overrun", PW'(overrun), PW'(0));

    // Same ramp, one valid every three cycles
    start_frame(1'b1);
    drive_frame(1, NPIX);
    drain("gap_drain");
    chk("gap_ready_count", PW'(rdy_cnt), PW'(64));

    // Random data, random gaps
    for (int f = 0; f < 2; f++) begin
      start_frame(1'b0);
      drive_frame(2, NPIX);
      drain($sformatf("rand%0d_drain", f));
      chk($sformatf("rand%0d_ready_count", f), PW'(rdy_cnt), PW'(64));
    end
    chk("pre_overrun", PW'(overrun), PW'(0));

    // Pixel of the next frame arrives while draining
    start_frame(1'b0);
    drive_frame(0, NPIX);
    valid     = 1'b1;
    input_act = PW'($urandom);
    @(negedge clk);
    valid = 1'b0;
    chk("overrun_set", PW'(overrun), PW'(1));
    drain("ovr_drain");
    chk("ovr_ready_count", PW'(rdy_cnt), PW'(64));
    start_frame(1'b0);
    drive_frame(2, NPIX);
    drain("post_ovr_drain");
    chk("post_ovr_ready_count", PW'(rdy_cnt), PW'(64));
    chk("overrun_sticky", PW'(overrun), PW'(1));

    // Reset after pixel 30, then a fresh full frame
    start_frame(1'b0);
    drive_frame(0, 31);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", PW'(ready), PW'(0));
    chk("midrst_overrun", PW'(overrun), PW'(0));
    chk("midrst_windows", PW'(rdy_cnt), PW'(22));
    chk("midrst_pending", PW'(exp_q.size()), PW'(42));
    for (int t = 0; t < 9; t++) chk($sformatf("midrst_out_t%0d", t), output_act[t * PW +: PW], '0);
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    start_frame(1'b0);
    drive_frame(2, NPIX);
    drain("newframe_drain");
    chk("newframe_ready_count", PW'(rdy_cnt), PW'(64));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
